mult_hilo_seq: RTL and testbench

//  Multi-cycle MULT/MULTU unit for the CPU datapath. It owns the HI/LO registers and

---
 rtl/mult_hilo_seq.sv | 89 ++++++++
 tb/tb_mult_hilo_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mult_hilo_seq.sv
// mult_hilo_seq: sequential shift-add MULT/MULTU unit owning HI/LO, with pipeline stall handshake.
// Operands are captured on start, turned into magnitudes, multiplied one bit per cycle, then sign-fixed.
module mult_hilo_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   cnt;
    logic               sgn, neg, last;

    assign last  = cnt == CNT_W'(WIDTH - 1);
    assign stall = busy & (start | mthi | mtlo | rd_req);

    always_comb begin
        state_next = state == IDLE ? (start ? PREP : IDLE) :
                     state == PREP ? RUN :
                     state == RUN  ? (last ? FIX : RUN) : IDLE;
        sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mplier[0] ? mcand : '0};
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_next;

    // mplier shifts right each RUN cycle, so bit 0 is always the current multiplier bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sgn    <= 1'b0;
            neg    <= 1'b0;
        end else begin
            busy <= state_next != IDLE;
            done <= state == FIX;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= rs_val;
                        mplier <= rt_val;
                        sgn    <= is_signed;
                        neg    <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    end else begin
                        if (mthi) hi <= wr_data;
                        if (mtlo) lo <= wr_data;
                    end
                end
                PREP: begin
                    mcand  <= sgn & mcand[WIDTH-1] ? -mcand : mcand;
                    mplier <= sgn & mplier[WIDTH-1] ? -mplier : mplier;
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                default: {hi, lo} <= neg ? -acc : acc;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_hilo_seq.sv
// tb_mult_hilo_seq: directed and random checks of mult_hilo_seq against an arithmetic product model.
module tb_mult_hilo_seq;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, is_signed = 1'b0;
    logic        mthi = 1'b0, mtlo = 1'b0, rd_req = 1'b0;
    logic [31:0] rs_val = '0, rt_val = '0, wr_data = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;
    int          n_checks = 0, n_fail = 0;

    mult_hilo_seq dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .rd_req(rd_req), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic s);
        return s ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present start, take E0, then scramble operands to prove they were captured
    task automatic launch(logic [31:0] a, logic [31:0] b, logic s);
        rs_val = a; rt_val = b; is_signed = s; start = 1'b1;
        chk("start_no_stall", 64'(stall), 0);
        tick();
        start = 1'b0; rs_val = $urandom; rt_val = $urandom; is_signed = ~s;
        chk("busy_after_e0", 64'(busy), 1);
    endtask

    task automatic wait_done(string tag, logic [31:0] a, logic [31:0] b, logic s);
        int k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, 64'(k), 34);
        chk({tag, "_prod"}, {hi, lo}, model(a, b, s));
        chk({tag, "_busy0"}, 64'(busy), 0);
    endtask

    task automatic mult(string tag, logic [31:0] a, logic [31:0] b, logic s);
        launch(a, b, s);
        wait_done(tag, a, b, s);
        tick();
        chk({tag, "_done_1cyc"}, 64'(done), 0);
    endtask

    initial begin
        int pulses, k;
        logic [31:0] a, b;
        logic s;
        tick(); tick();
        chk("rst_state", {hi, lo}, 0);
        chk("rst_flags", {61'b0, busy, done, stall}, 0);
        reset = 1'b0;
        tick();

        mult("multu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_ff_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        mult("mult_m3x5", 32'hFFFF_FFFD, 32'h5, 1'b1);
        chk("mult_m3x5_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        mult("mult_m7xm6", -32'sd7, -32'sd6, 1'b1);
        chk("mult_m7xm6_exact", {hi, lo}, 64'h2A);
        mult("mult_min", 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("mult_min_exact", {hi, lo}, 64'h4000_0000_0000_0000);
        mult("multu_min2", 32'h8000_0000, 32'h2, 1'b0);
        chk("multu_min2_exact", {hi, lo}, 64'h1_0000_0000);

        // held requests during a multiply all stall and have no effect
        launch(32'd1000, 32'd77, 1'b0);
        rs_val = 32'd9; rt_val = 32'd11; is_signed = 1'b0;
        start = 1'b1; rd_req = 1'b1; mtlo = 1'b1; wr_data = 32'hFFFF_0000;
        k = 0;
        while (!done && k < 100) begin
            chk("held_stall", 64'(stall), 1);
            tick();
            k++;
        end
        chk("held_latency", 64'(k), 34);
        chk("held_prod", {hi, lo}, 64'd77000);
        chk("held_stall_free", 64'(stall), 0);
        tick();
        chk("second_taken", 64'(busy), 1);
        chk("start_beats_mtlo", 64'(lo), 64'd77000);
        start = 1'b0; rd_req = 1'b0; mtlo = 1'b0;
        wait_done("second", 32'd9, 32'd11, 1'b0);

        // asynchronous reset 10 clocks into RUN
        launch(32'h1234_5678, 32'h0BAD_F00D, 1'b1);
        repeat (11) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_flags", {62'b0, busy, done}, 0);
        chk("arst_hilo", {hi, lo}, 0);
        tick();
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            tick();
            pulses += int'(done);
        end
        chk("arst_no_done", 64'(pulses), 0);
        mult("after_rst", 32'd3, 32'd4, 1'b0);
        chk("after_rst_lo", 64'(lo), 64'hC);

        // HI/LO moves in IDLE
        mthi = 1'b1; wr_data = 32'h1234_5678;
        #1 chk("mthi_no_stall", 64'(stall), 0);
        tick();
        mthi = 1'b0; mtlo = 1'b1; wr_data = 32'h9ABC_DEF0;
        tick();
        mtlo = 1'b0;
        chk("mthi_mtlo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h5555_AAAA;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_and_mtlo", {hi, lo}, 64'h5555_AAAA_5555_AAAA);
        mthi = 1'b1; wr_data = 32'hDEAD_BEEF; rd_req = 1'b1;
        launch(32'd5, 32'd6, 1'b0);
        mthi = 1'b0; rd_req = 1'b0;
        chk("start_beats_mthi", 64'(hi), 64'h5555_AAAA);
        wait_done("start_mthi", 32'd5, 32'd6, 1'b0);

        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom);
            mult("rand", a, b, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
